// File: rtl/conv_col_packer_if.sv
// Purpose : pixel-in / column-out bundle of the column packer.
// Ports   : i_pixel/i_valid/o_ready (pixel side), o_col/o_col_valid/i_col_ready,
//           o_col_idx, o_frame_done, o_drop (column side).
// slave = the packer itself, master = the surrounding environment.
interface conv_col_packer_if #(
  parameter int IMG_HEIGHT = 480,
  parameter int IMG_WIDTH  = 640,
  parameter int IN_NB      = 19,
  parameter int OUT_NB     = 8
);
  localparam int IDX_NB = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic [IN_NB-1:0]             i_pixel;
  logic                         i_valid;
  logic                         o_ready;
  logic [IMG_HEIGHT*OUT_NB-1:0] o_col;
  logic                         o_col_valid;
  logic                         i_col_ready;
  logic [IDX_NB-1:0]            o_col_idx;
  logic                         o_frame_done;
  logic                         o_drop;

  modport slave (
    input  i_pixel, i_valid, i_col_ready,
    output o_ready, o_col, o_col_valid, o_col_idx, o_frame_done, o_drop
  );

  modport master (
    output i_pixel, i_valid, i_col_ready,
    input  o_ready, o_col, o_col_valid, o_col_idx, o_frame_done, o_drop
  );
endinterface

// File: rtl/conv_col_packer.sv
// Purpose     : scale/clip signed conv results to unsigned pixels, pack IMG_HEIGHT of them into one MSB-first column.
// Latency     : column presented one edge after its last pixel is accepted (later if the previous column is still held).
// Backpressure: o_ready drops for the FULL cycle(s); pixels offered then are discarded and flagged sticky on o_drop.
// Ports: clk100, in_reset (sync, active-low), bus (slave modport of conv_col_packer_if).
module conv_col_packer #(
  parameter int IMG_HEIGHT = 480,
  parameter int IMG_WIDTH  = 640,
  parameter int IN_NB      = 19,
  parameter int OUT_NB     = 8,
  parameter int SHIFT      = 0
) (
  input  logic             clk100,
  input  logic             in_reset,
  conv_col_packer_if.slave bus
);
  localparam int CNT_NB = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int IDX_NB = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_NB-1:0] LAST_SLOT = CNT_NB'(IMG_HEIGHT - 1);
  localparam logic [IDX_NB-1:0] LAST_COL  = IDX_NB'(IMG_WIDTH - 1);
  localparam logic [OUT_NB-1:0] PIX_MAX   = '1;

  typedef enum logic {FILL, FULL} state_t;

  state_t                       state_q, state_d;
  logic [CNT_NB-1:0]            cnt_q;
  logic [OUT_NB-1:0]            fill_mem [IMG_HEIGHT];
  logic [IMG_HEIGHT*OUT_NB-1:0] fill_flat;
  logic [IMG_HEIGHT*OUT_NB-1:0] col_q;
  logic                         col_vld_q;
  logic [IDX_NB-1:0]            idx_q;
  logic                         done_q;
  logic                         drop_q;

  logic                         ready;
  logic                         copy;
  logic                         accept;
  logic                         handoff;
  logic signed [IN_NB-1:0]      shifted;
  logic [OUT_NB-1:0]            scaled;

  // Sign bit set -> clamp to 0; any set bit above the output width -> saturate.
  always_comb begin
    shifted = $signed(bus.i_pixel) >>> SHIFT;
    if (shifted[IN_NB-1])
      scaled = '0;
    else if (|shifted[IN_NB-2:OUT_NB])
      scaled = PIX_MAX;
    else
      scaled = shifted[OUT_NB-1:0];
  end

  // FULL holds the completed column until the output register is free or
  // being emptied this very cycle, which gives a bubble-free handover.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    copy    = 1'b0;
    case (state_q)
      FILL: begin
        ready = 1'b1;
        if (bus.i_valid && cnt_q == LAST_SLOT)
          state_d = FULL;
      end
      FULL: begin
        if (!col_vld_q || bus.i_col_ready) begin
          copy    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign accept  = bus.i_valid && ready;
  assign handoff = col_vld_q && bus.i_col_ready;

  // Slot 0 lands in the most significant byte of the column.
  always_comb begin
    fill_flat = '0;
    for (int k = 0; k < IMG_HEIGHT; k++)
      fill_flat[(IMG_HEIGHT-k)*OUT_NB-1 -: OUT_NB] = fill_mem[k];
  end

  always_ff @(posedge clk100) begin
    if (!in_reset) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      col_q     <= '0;
      col_vld_q <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      for (int k = 0; k < IMG_HEIGHT; k++)
        fill_mem[k] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= handoff && (idx_q == LAST_COL);
      if (bus.i_valid && !ready)
        drop_q <= 1'b1;
      if (accept) begin
        fill_mem[cnt_q] <= scaled;
        cnt_q           <= (cnt_q == LAST_SLOT) ? '0 : cnt_q + 1'b1;
      end
      if (handoff)
        idx_q <= (idx_q == LAST_COL) ? '0 : idx_q + 1'b1;
      // A copy wins over a plain handoff so valid never dips on back-to-back columns.
      if (copy) begin
        col_q     <= fill_flat;
        col_vld_q <= 1'b1;
      end else if (handoff) begin
        col_vld_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_col        = col_q;
  assign bus.o_col_valid  = col_vld_q;
  assign bus.o_col_idx    = idx_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_drop       = drop_q;
endmodule

// File: tb/tb_conv_col_packer.sv
module tb_conv_col_packer;
  localparam int H  = 480;
  localparam int W  = 8;
  localparam int H2 = 4;
  localparam int W2 = 4;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;
  logic in_reset;

  conv_col_packer_if #(.IMG_HEIGHT(H),  .IMG_WIDTH(W),  .IN_NB(19), .OUT_NB(8)) bus ();
  conv_col_packer_if #(.IMG_HEIGHT(H2), .IMG_WIDTH(W2), .IN_NB(19), .OUT_NB(8)) bus2 ();

  conv_col_packer #(.IMG_HEIGHT(H), .IMG_WIDTH(W), .IN_NB(19), .OUT_NB(8), .SHIFT(0)) dut (
    .clk100(clk100), .in_reset(in_reset), .bus(bus.slave));
  conv_col_packer #(.IMG_HEIGHT(H2), .IMG_WIDTH(W2), .IN_NB(19), .OUT_NB(8), .SHIFT(2)) dut2 (
    .clk100(clk100), .in_reset(in_reset), .bus(bus2.slave));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int vld_low  = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] slot(input logic [H*8-1:0] v, input int k);
    return v[(H-k)*8-1 -: 8];
  endfunction

  task automatic check_col(input string name, input logic [H*8-1:0] act, input logic [H*8-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      int k;
      n_fail++;
      k = 0;
      while (k < H-1 && slot(act, k) === slot(exp, k)) k++;
      $display("FAIL %s: slot %0d got 0x%0h, want 0x%0h", name, k, slot(act, k), slot(exp, k));
    end
  endtask

  // Reference scaling straight from the arithmetic rule: shift, then clamp to 0..255.
  function automatic logic [7:0] scale_ref(input logic [18:0] p, input int sh);
    int s;
    s = int'($signed(p));
    s = s >>> sh;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  // Behavioural model: partial column, one completed-but-parked column, presented column.
  logic [7:0]     m_part [H];
  int             m_cnt;
  bit             m_wait;
  logic [H*8-1:0] m_wait_col;
  logic [H*8-1:0] m_out_col;
  bit             m_out_vld;
  int             m_idx;
  bit             m_done;
  bit             m_drop;

  always @(posedge clk100) begin
    if (!in_reset) begin
      m_cnt = 0; m_wait = 1'b0; m_wait_col = '0; m_out_col = '0;
      m_out_vld = 1'b0; m_idx = 0; m_done = 1'b0; m_drop = 1'b0;
    end else begin
      bit ho, mv, acc;
      ho  = m_out_vld && bus.i_col_ready;
      mv  = m_wait && (!m_out_vld || bus.i_col_ready);
      acc = bus.i_valid && !m_wait;
      if (bus.i_valid && m_wait) m_drop = 1'b1;
      m_done = ho && (m_idx == W-1);
      if (ho) begin
        m_idx = (m_idx + 1) % W;
        m_out_vld = 1'b0;
      end
      if (mv) begin
        m_out_col = m_wait_col;
        m_out_vld = 1'b1;
        m_wait = 1'b0;
      end
      if (acc) begin
        m_part[m_cnt] = scale_ref(bus.i_pixel, 0);
        m_cnt++;
        if (m_cnt == H) begin
          for (int k = 0; k < H; k++) m_wait_col[(H-k)*8-1 -: 8] = m_part[k];
          m_wait = 1'b1;
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk100) begin
    if (chk_en) begin
      check("cmp o_ready", bus.o_ready, !m_wait);
      check("cmp o_col_valid", bus.o_col_valid, m_out_vld);
      check("cmp o_col_idx", bus.o_col_idx, m_idx);
      check("cmp o_frame_done", bus.o_frame_done, m_done);
      check("cmp o_drop", bus.o_drop, m_drop);
      check_col("cmp o_col", bus.o_col, m_out_col);
      if (bus.o_col_valid !== 1'b1) vld_low++;
      if (bus.o_frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic drive(input bit v, input logic [18:0] p);
    bus.i_valid = v;
    bus.i_pixel = p;
    tick();
  endtask

  task automatic drive2(input bit v, input logic [18:0] p);
    bus2.i_valid = v;
    bus2.i_pixel = p;
    tick();
  endtask

  task automatic pulse_reset();
    bus.i_valid = 1'b0;
    in_reset = 1'b0;
    tick();
    in_reset = 1'b1;
  endtask

  // One full column followed by a single idle cycle covering the FULL state.
  task automatic send_col(input int c);
    for (int k = 0; k < H; k++) drive(1'b1, 19'((c*53 + k*7) % 600 - 100));
    drive(1'b0, '0);
  endtask

  initial begin
    in_reset = 1'b0;
    bus.i_valid = 1'b0; bus.i_pixel = '0; bus.i_col_ready = 1'b0;
    bus2.i_valid = 1'b0; bus2.i_pixel = '0; bus2.i_col_ready = 1'b0;
    tick(); tick(); tick();
    chk_en = 1'b1;
    check("reset o_col_valid", bus.o_col_valid, 1'b0);
    check("reset o_ready", bus.o_ready, 1'b1);
    check("reset o_col_idx", bus.o_col_idx, 0);
    in_reset = 1'b1;

    // SHIFT=2 instance: 8->2, 1023->255, -4->0, 1->0
    drive2(1'b1, 19'd8);
    drive2(1'b1, 19'd1023);
    drive2(1'b1, 19'h7FFFC);
    drive2(1'b1, 19'd1);
    drive2(1'b0, '0);
    check("shift2 o_col_valid", bus2.o_col_valid, 1'b1);
    check("shift2 column", bus2.o_col, 64'h02FF0000);

    // Column 0: ramp 0..479, consumer idle
    for (int k = 0; k < H; k++) drive(1'b1, 19'(k));
    bus.i_valid = 1'b0;
    check("t1 valid low at last accept", bus.o_col_valid, 1'b0);
    check("t1 ready low in FULL", bus.o_ready, 1'b0);
    drive(1'b0, '0);
    check("t1 valid one edge later", bus.o_col_valid, 1'b1);
    check("t1 slot0", slot(bus.o_col, 0), 8'd0);
    check("t1 slot254", slot(bus.o_col, 254), 8'd254);
    check("t1 slot255", slot(bus.o_col, 255), 8'd255);
    check("t1 slot479", slot(bus.o_col, 479), 8'd255);
    check("t1 idx", bus.o_col_idx, 0);
    vld_low = 0;

    // Column 1: clip values up front, consumer still idle -> parked in FULL
    for (int k = 0; k < H; k++) begin
      case (k)
        0: drive(1'b1, 19'h7FFFF);
        1: drive(1'b1, 19'h40000);
        2: drive(1'b1, 19'd256);
        3: drive(1'b1, 19'h3FFFF);
        default: drive(1'b1, 19'(k));
      endcase
    end
    drive(1'b0, '0);
    check("t3 stuck ready", bus.o_ready, 1'b0);
    check("t3 drop clear before pulse", bus.o_drop, 1'b0);
    drive(1'b1, 19'd123);
    bus.i_valid = 1'b0;
    check("t3 drop set", bus.o_drop, 1'b1);
    check("t3 still col0", bus.o_col_idx, 0);
    bus.i_col_ready = 1'b1;
    drive(1'b0, '0);
    bus.i_col_ready = 1'b0;
    check("t3 col1 valid", bus.o_col_valid, 1'b1);
    check("t3 col1 idx", bus.o_col_idx, 1);
    check("t2 -1 -> 0", slot(bus.o_col, 0), 8'd0);
    check("t2 most neg -> 0", slot(bus.o_col, 1), 8'd0);
    check("t2 256 -> 255", slot(bus.o_col, 2), 8'd255);
    check("t2 3FFFF -> 255", slot(bus.o_col, 3), 8'd255);
    check("t2 4 -> 4", slot(bus.o_col, 4), 8'd4);

    // Column 2: consumer accepts exactly on the FULL cycle
    for (int k = 0; k < H; k++) drive(1'b1, 19'(k*4 - 500));
    bus.i_valid = 1'b0;
    check("t4 old col held", bus.o_col_idx, 1);
    bus.i_col_ready = 1'b1;
    drive(1'b0, '0);
    bus.i_col_ready = 1'b0;
    check("t4 idx", bus.o_col_idx, 2);
    check("t4 no valid gap", vld_low, 0);
    check("t4 slot0", slot(bus.o_col, 0), 8'd0);
    check("t4 slot130", slot(bus.o_col, 130), 8'd20);
    check("t4 slot200", slot(bus.o_col, 200), 8'd255);
    check("t4 drop sticky", bus.o_drop, 1'b1);

    // Frame wrap with an always-ready consumer
    pulse_reset();
    bus.i_col_ready = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < W; c++) send_col(c);
    drive(1'b0, '0); drive(1'b0, '0); drive(1'b0, '0);
    check("t5 frame_done count", done_cnt, 1);
    check("t5 idx wrapped", bus.o_col_idx, 0);
    check("t5 no drop", bus.o_drop, 1'b0);

    // Reset mid-column while a column is presented
    pulse_reset();
    send_col(0); send_col(1);
    drive(1'b0, '0);
    bus.i_col_ready = 1'b0;
    send_col(2);
    for (int k = 0; k < 100; k++) drive(1'b1, 19'(k + 9));
    check("t6 valid before reset", bus.o_col_valid, 1'b1);
    check("t6 idx before reset", bus.o_col_idx, 2);
    pulse_reset();
    check("t6 rst valid", bus.o_col_valid, 1'b0);
    check("t6 rst col", (bus.o_col == '0), 1'b1);
    check("t6 rst idx", bus.o_col_idx, 0);
    check("t6 rst drop", bus.o_drop, 1'b0);
    for (int k = 0; k < H; k++) drive(1'b1, 19'(k));
    drive(1'b0, '0);
    check("t6 clean valid", bus.o_col_valid, 1'b1);
    check("t6 clean idx", bus.o_col_idx, 0);
    check("t6 slot0", slot(bus.o_col, 0), 8'd0);
    check("t6 slot100", slot(bus.o_col, 100), 8'd100);
    check("t6 slot479", slot(bus.o_col, 479), 8'd255);

    drive(1'b0, '0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
